block_dropper: RTL and testbench
================================

# block_dropper

Falling-block source for the stacking game: picks a pseudo-random column and colour, drops the block down the screen at a tick-divided rate, and respawns it when the platform stack reports a catch or the block reaches the floor. Its `fall_x`, `fall_y` and `fall_color` outputs drive the stack's falling-block inputs and the VGA renderer. The stack's collision output returns as `caught`.

## Interface
- `SCREEN_W`, 640: screen width in pixels.
- `BLOCK_W`, 30: falling block width. `X_MAX = SCREEN_W - BLOCK_W` must satisfy 511 ≤ X_MAX ≤ 1023.
- `SPAWN_Y`, 0: `fall_y` value at spawn.
- `FLOOR_Y`, 470: `fall_y` at which the block counts as missed.
- `TICK_BITS`, 18: width of the fall-rate divider.
- `SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: game running. Low forces IDLE.
- `speed`, input, 2: fall step per tick is `speed + 1` pixels (1..4).
- `caught`, input, 1: stack collision indication. Sampled only in FALL.
- `fall_x`, output, 10: block left x, range 0..X_MAX.
- `fall_y`, output, 10: block top y.
- `fall_color`, output, 2: block colour, never 2'b00.
- `falling`, output, 1: block is live and collidable.
- `miss`, output, 1: one-cycle pulse when a block reaches the floor.
- `drops`, output, 8: count of blocks spawned; wraps at 256.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11: `fb = l[15]^l[13]^l[12]^l[10]`, next `l = {l[14:0], fb}`.
  - Advances every clk in every state.
- **Divider**
  - TICK_BITS-bit counter, increments every clk and wraps.
  - `tick` is high in the cycle the counter equals all-ones.
- **Column mapping**
  - `r = l[9:0]`.
  - `x = (r > X_MAX) ? r - X_MAX - 1 : r`.
  - A single subtraction suffices given the X_MAX constraint.
- **Colour mapping**
  - `c = l[11:10]`; if `c == 0` use 2'b01.
- **States:** IDLE, SPAWN, FALL, CLEAR, MISS.
  - IDLE: `falling=0`. If `enable=1`, go to SPAWN.
  - SPAWN, one cycle:
    - latch `fall_x` and `fall_color` from the current LFSR value;
    - set `fall_y=SPAWN_Y`;
    - increment `drops`;
    - go to FALL.
  - FALL: `falling=1`.
    - If `caught`, go to CLEAR.
    - Else if `tick`:
      - compute `ny = fall_y + speed + 1` at 11-bit width;
      - if `ny ≥ FLOOR_Y`, set `fall_y=FLOOR_Y` and go to MISS;
      - else set `fall_y=ny`.
  - CLEAR, one cycle: `falling=0`, position held. Go to SPAWN.
  - MISS, one cycle: `falling=0`, `miss=1`. Go to SPAWN.
- **Priority:** in FALL, `caught` wins over `tick` in the same cycle; `fall_y` is not advanced.
- **Enable low:** `enable=0` in any state moves to IDLE next cycle with `fall_y=SPAWN_Y`.
  - `fall_x` and `fall_color` hold.
  - No `miss` pulse is generated.
  - `drops` holds.
- **Caught outside FALL:** `caught` in IDLE, SPAWN, CLEAR or MISS is ignored.

## Timing
- **Reset values:**
  - state IDLE, `l=SEED`, divider 0;
  - `fall_x=0`, `fall_y=SPAWN_Y`, `fall_color=2'b01`;
  - `falling=0`, `miss=0`, `drops=0`.
- **Registered outputs:** all outputs are registered and change only on clk rising edges, apart from the asynchronous reset.
- **Enable rise:** enable rising in cycle N gives SPAWN at N+1 and FALL at N+2, with `falling=1` visible from N+2.
- **Caught:** `caught` sampled in FALL at cycle N gives CLEAR at N+1, SPAWN at N+2, and the new block live at N+3.
- **Floor:** floor reached on the tick at cycle N gives MISS at N+1 with `miss=1`, then SPAWN at N+2 and the new block live at N+3.
- **Fall period:** FALL advances at most once per 2^TICK_BITS cycles. The first tick after spawn may arrive after fewer cycles, because the divider is free-running.
- **Reset mid-fall:** returns to the reset values immediately. The block is not counted as a miss.

## Test plan
- **Reset defaults.** Assert rst mid-FALL → all outputs at reset values in the same cycle. After release with `enable=0`, `falling` stays 0 indefinitely.
- **Fall and miss.** TICK_BITS=2, FLOOR_Y=20, speed=3, enable high → `fall_y` steps 0,4,8,12,16,20 every 4 cycles. The tick that reaches 20 is followed by `miss=1` for exactly one cycle, then a respawn with `fall_y=0` and `drops=2`.
- **Clamp.** FLOOR_Y=470, speed=3, `fall_y=468` at a tick → `fall_y=470`, state MISS. The 11-bit sum never wraps.
- **Catch priority.** `caught=1` coinciding with `tick` in FALL → `fall_y` unchanged, `falling=0` next cycle, new block live 3 cycles after `caught`, `miss` never asserted.
- **Column and colour mapping.** Force the LFSR to each of the following at SPAWN and check the latched values:
  - `l[9:0]` = 1023 → `fall_x` = 412;
  - 611 → 0;
  - 610 → 610;
  - 0 → 0;
  - `l[11:10]=00` → colour 01.
  - Over 10 000 spawns, `fall_x ≤ 610` and `fall_color ≠ 0` always.
- **Enable drop.** Deassert enable mid-FALL → IDLE next cycle, `fall_y=0`, no `miss` pulse, `drops` unchanged. Re-enable → exactly one SPAWN and `drops` increments by 1.

Source files
------------

// File: rtl/block_dropper.sv
// block_dropper: falling-block source for the stacking game.
// Picks a pseudo-random column and colour from a free-running LFSR, drops the
// block at a tick-divided rate, and respawns it on a catch or when it reaches
// the floor. All outputs are registered.

module block_dropper #(
  parameter int          SCREEN_W  = 640,
  parameter int          BLOCK_W   = 30,
  parameter int          SPAWN_Y   = 0,
  parameter int          FLOOR_Y   = 470,
  parameter int          TICK_BITS = 18,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       caught,
  output logic [9:0] fall_x,
  output logic [9:0] fall_y,
  output logic [1:0] fall_color,
  output logic       falling,
  output logic       miss,
  output logic [7:0] drops
);

  // Rightmost legal left edge; assumed to lie in 511..1023 so that a single
  // wrap-around subtraction folds any 10-bit value into 0..X_MAX.
  localparam int         X_MAX     = SCREEN_W - BLOCK_W;
  localparam logic [9:0] X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0] SPAWN_Y_V = 10'(SPAWN_Y);
  localparam logic [9:0] FLOOR_Y_V = 10'(FLOOR_Y);
  localparam logic [10:0] FLOOR_Y_W = 11'(FLOOR_Y);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FALL,
    ST_CLEAR,
    ST_MISS
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [TICK_BITS-1:0] div_q, div_d;
  logic [9:0]           fall_x_q, fall_x_d;
  logic [9:0]           fall_y_q, fall_y_d;
  logic [1:0]           fall_color_q, fall_color_d;
  logic                 falling_q, falling_d;
  logic                 miss_q, miss_d;
  logic [7:0]           drops_q, drops_d;

  logic                 tick;
  logic [10:0]          ny;
  logic                 floor_hit;

  // Fold a raw 10-bit random value into the legal column range.
  function automatic logic [9:0] map_column(input logic [9:0] r);
    if (r > X_MAX_V) begin
      return r - X_MAX_V - 10'd1;
    end
    return r;
  endfunction

  // Colour 00 is reserved for background, so it is remapped to 01.
  function automatic logic [1:0] map_colour(input logic [1:0] c);
    if (c == 2'b00) begin
      return 2'b01;
    end
    return c;
  endfunction

  // Saturate the widened next-y sum at the floor.
  function automatic logic [9:0] clamp_floor(input logic [10:0] sum);
    if (sum >= FLOOR_Y_W) begin
      return FLOOR_Y_V;
    end
    return sum[9:0];
  endfunction

  // Next-state logic: free-running LFSR and divider, then the drop FSM.
  always_comb begin
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    div_d        = div_q + TICK_BITS'(1);
    tick         = &div_q;
    // 11-bit sum so a step from near 1023 cannot wrap before the floor test.
    ny           = {1'b0, fall_y_q} + {9'd0, speed} + 11'd1;
    floor_hit    = (ny >= FLOOR_Y_W);

    state_d      = state_q;
    fall_x_d     = fall_x_q;
    fall_y_d     = fall_y_q;
    fall_color_d = fall_color_q;
    drops_d      = drops_q;

    if (!enable) begin
      // Abandon the current block silently: no miss, no count change.
      state_d  = ST_IDLE;
      fall_y_d = SPAWN_Y_V;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SPAWN;
        end
        ST_SPAWN: begin
          fall_x_d     = map_column(lfsr_q[9:0]);
          fall_color_d = map_colour(lfsr_q[11:10]);
          fall_y_d     = SPAWN_Y_V;
          drops_d      = drops_q + 8'd1;
          state_d      = ST_FALL;
        end
        ST_FALL: begin
          // A catch freezes the block where it is, even on a tick cycle.
          if (caught) begin
            state_d = ST_CLEAR;
          end else if (tick) begin
            fall_y_d = clamp_floor(ny);
            if (floor_hit) begin
              state_d = ST_MISS;
            end
          end
        end
        ST_CLEAR: begin
          state_d = ST_SPAWN;
        end
        ST_MISS: begin
          state_d = ST_SPAWN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status flags are registered copies of the state being entered.
    falling_d = (state_d == ST_FALL);
    miss_d    = (state_d == ST_MISS);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED;
      div_q        <= '0;
      fall_x_q     <= 10'd0;
      fall_y_q     <= SPAWN_Y_V;
      fall_color_q <= 2'b01;
      falling_q    <= 1'b0;
      miss_q       <= 1'b0;
      drops_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      div_q        <= div_d;
      fall_x_q     <= fall_x_d;
      fall_y_q     <= fall_y_d;
      fall_color_q <= fall_color_d;
      falling_q    <= falling_d;
      miss_q       <= miss_d;
      drops_q      <= drops_d;
    end
  end

  assign fall_x     = fall_x_q;
  assign fall_y     = fall_y_q;
  assign fall_color = fall_color_q;
  assign falling    = falling_q;
  assign miss       = miss_q;
  assign drops      = drops_q;

endmodule

// File: tb/tb_block_dropper.sv
// Directed testbench for block_dropper.
// u_main: fast divider, low floor (fall/miss, catch, enable drop, spawn sweep).
// u_clamp: fast divider, floor 470 (clamp at the floor).
// u_map[k]: seeds chosen so the first spawn sees a chosen LFSR value.

module tb_block_dropper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Seed whose successor is t (inverse of the Fibonacci shift).
  function automatic logic [15:0] lfsr_prev(input logic [15:0] t);
    return {t[0] ^ t[14] ^ t[13] ^ t[11], t[15:1]};
  endfunction

  // Target LFSR values seen at SPAWN: {colour bits, column bits}.
  function automatic logic [15:0] map_target(input int k);
    case (k)
      0:       return 16'h03FF;  // col 1023, colour 00
      1:       return 16'h0E63;  // col 611,  colour 11
      2:       return 16'h0A62;  // col 610,  colour 10
      default: return 16'h0400;  // col 0,    colour 01
    endcase
  endfunction

  function automatic int exp_x(input int k);
    case (k)
      0:       return 412;
      1:       return 0;
      2:       return 610;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_c(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Main instance
  logic       enable_a, caught_a;
  logic [1:0] speed_a;
  logic [9:0] x_a, y_a;
  logic [1:0] c_a;
  logic       fall_a, miss_a;
  logic [7:0] drops_a;

  block_dropper #(.TICK_BITS(2), .FLOOR_Y(20)) u_main (
    .clk(clk), .rst(rst), .enable(enable_a), .speed(speed_a), .caught(caught_a),
    .fall_x(x_a), .fall_y(y_a), .fall_color(c_a), .falling(fall_a),
    .miss(miss_a), .drops(drops_a)
  );

  // Clamp instance
  logic       enable_c;
  logic [9:0] x_c, y_c;
  logic [1:0] c_c;
  logic       fall_c, miss_c;
  logic [7:0] drops_c;

  block_dropper #(.TICK_BITS(2), .FLOOR_Y(470)) u_clamp (
    .clk(clk), .rst(rst), .enable(enable_c), .speed(2'd3), .caught(1'b0),
    .fall_x(x_c), .fall_y(y_c), .fall_color(c_c), .falling(fall_c),
    .miss(miss_c), .drops(drops_c)
  );

  // Mapping instances
  logic       enable_m;
  logic [9:0] x_m [4];
  logic [9:0] y_m [4];
  logic [1:0] c_m [4];
  logic       fall_m [4];
  logic       miss_m [4];
  logic [7:0] drops_m [4];

  for (genvar k = 0; k < 4; k++) begin : g_map
    block_dropper #(.SEED(lfsr_prev(map_target(k)))) u_map (
      .clk(clk), .rst(rst), .enable(enable_m), .speed(2'd0), .caught(1'b0),
      .fall_x(x_m[k]), .fall_y(y_m[k]), .fall_color(c_m[k]), .falling(fall_m[k]),
      .miss(miss_m[k]), .drops(drops_m[k])
    );
  end

  task automatic wait_y_change(input logic [9:0] from, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (y_a == from && n < 40);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},       int'(x_a), 0);
    check({tag, "_y"},       int'(y_a), 0);
    check({tag, "_colour"},  int'(c_a), 1);
    check({tag, "_falling"}, int'(fall_a), 0);
    check({tag, "_miss"},    int'(miss_a), 0);
    check({tag, "_drops"},   int'(drops_a), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int spawns;
    logic prev_fall;
    logic [9:0] saved_x;
    logic [1:0] saved_c;
    logic [9:0] last_c;

    rst = 1'b1; enable_a = 1'b0; speed_a = 2'd3; caught_a = 1'b0;
    enable_c = 1'b0; enable_m = 1'b1;
    repeat (3) step();
    check_reset_values("rst");
    rst = 1'b0;

    // Mapping instances: SPAWN after one edge, latched values after two.
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      check("map_x",       int'(x_m[k]), exp_x(k));
      check("map_colour",  int'(c_m[k]), exp_c(k));
      check("map_falling", int'(fall_m[k]), 1);
      check("map_y",       int'(y_m[k]), 0);
      check("map_miss",    int'(miss_m[k]), 0);
      check("map_drops",   int'(drops_m[k]), 1);
    end

    // Enable low keeps the main block idle.
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_falling", int'(fall_a), 0);
    end

    // Enable rise: SPAWN next cycle, live the cycle after.
    enable_a = 1'b1;
    step();
    check("spawn_falling", int'(fall_a), 0);
    check("spawn_drops",   int'(drops_a), 0);
    step();
    check("live_falling", int'(fall_a), 1);
    check("live_drops",   int'(drops_a), 1);
    check("live_y",       int'(y_a), 0);

    // Fall 0,4,8,12,16,20 then miss.
    for (int s = 1; s <= 5; s++) begin
      wait_y_change(y_a, n);
      check("fall_y", int'(y_a), s * 4);
      if (s > 1) check("fall_period", n, 4);
      if (s < 5) begin
        check("fall_miss_low", int'(miss_a), 0);
        check("fall_live",     int'(fall_a), 1);
      end
    end
    check("miss_pulse",   int'(miss_a), 1);
    check("miss_falling", int'(fall_a), 0);
    step();
    check("miss_one_cycle", int'(miss_a), 0);
    check("respawn_idle",   int'(fall_a), 0);
    step();
    check("respawn_live",  int'(fall_a), 1);
    check("respawn_y",     int'(y_a), 0);
    check("respawn_drops", int'(drops_a), 2);
    check("respawn_miss",  int'(miss_a), 0);

    // Catch coinciding with a tick.
    wait_y_change(10'd0, n);
    check("catch_pre_y", int'(y_a), 4);
    step(); step(); step();
    caught_a = 1'b1;
    step();
    check("catch_y_hold",  int'(y_a), 4);
    check("catch_falling", int'(fall_a), 0);
    check("catch_miss",    int'(miss_a), 0);
    caught_a = 1'b0;
    step();
    check("catch_spawn_falling", int'(fall_a), 0);
    check("catch_spawn_miss",    int'(miss_a), 0);
    step();
    check("catch_live",  int'(fall_a), 1);
    check("catch_y",     int'(y_a), 0);
    check("catch_drops", int'(drops_a), 3);

    // Enable drop mid-fall.
    wait_y_change(10'd0, n);
    check("drop_pre_y", int'(y_a), 4);
    saved_x = x_a;
    saved_c = c_a;
    enable_a = 1'b0;
    step();
    check("drop_y",       int'(y_a), 0);
    check("drop_falling", int'(fall_a), 0);
    check("drop_miss",    int'(miss_a), 0);
    check("drop_drops",   int'(drops_a), 3);
    check("drop_x_hold",  int'(x_a), int'(saved_x));
    check("drop_c_hold",  int'(c_a), int'(saved_c));
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_idle_miss",    int'(miss_a), 0);
      check("drop_idle_falling", int'(fall_a), 0);
    end
    enable_a = 1'b1;
    step();
    check("reen_spawn_drops", int'(drops_a), 3);
    step();
    check("reen_live",  int'(fall_a), 1);
    check("reen_drops", int'(drops_a), 4);
    step(); step();
    check("reen_single_spawn", int'(drops_a), 4);

    // Spawn sweep: catch every block, check ranges and drop count wrap.
    caught_a = 1'b1;
    spawns = 0;
    prev_fall = fall_a;
    for (int i = 0; i < 40000 && spawns < 10000; i++) begin
      step();
      if (fall_a && !prev_fall) begin
        spawns++;
        check("sweep_x_range",  int'(x_a <= 10'd610), 1);
        check("sweep_colour",   int'(c_a != 2'b00), 1);
      end
      prev_fall = fall_a;
    end
    check("sweep_spawns", spawns, 10000);
    check("sweep_drops_wrap", int'(drops_a), 20);
    caught_a = 1'b0;

    // Reset mid-fall takes effect immediately.
    wait_y_change(10'd0, n);
    check("rstmid_pre_y", int'(y_a), 4);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("rstmid");
    enable_a = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_falling", int'(fall_a), 0);
      check("post_rst_miss",    int'(miss_a), 0);
    end

    // Clamp at floor 470 with speed 3: ... 464, 468, 470.
    enable_c = 1'b1;
    last_c = y_c;
    for (int i = 0; i < 700 && y_c != 10'd470; i++) begin
      last_c = y_c;
      step();
    end
    check("clamp_prev_y",  int'(last_c), 468);
    check("clamp_y",       int'(y_c), 470);
    check("clamp_miss",    int'(miss_c), 1);
    check("clamp_falling", int'(fall_c), 0);
    check("clamp_drops",   int'(drops_c), 1);
    check("clamp_x_range", int'(x_c <= 10'd610), 1);
    check("clamp_colour",  int'(c_c != 2'b00), 1);
    step();
    check("clamp_miss_one", int'(miss_c), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
